sr_prbs_checker: RTL and testbench
==================================

Name: sr_prbs_checker

Overview:
Loopback test engine for the latch-chain shift register. It drives a PRBS7 stream into the chain's serial input at one bit per shift period (BIT_CYCLES clocks), then samples the chain's serial output. Each received bit is compared against a copy of the sequence delayed by DEPTH shift periods. Mismatches are counted and a pass/fail verdict is reported. The block sits in the top level between the chain's sr_in/sr_out and the user pins, and shares clk and rst_n with the chain's two-phase clock generator.

Parameters:
DEPTH, 64, chain latency in shift periods (latch count / 2)
BIT_CYCLES, 4, clk cycles per shift period (must equal the two-phase generator cycle)
SAMPLE_PHASE, 3, phase index (0..BIT_CYCLES-1) at which sr_out_i is sampled
NUM_BITS, 256, number of received bits checked per run
ERR_W, 8, error counter width

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
start  input  1  single-cycle pulse; begins a run when idle
sr_out_i  input  1  serial output of the shift register under test
sr_in_o  output  1  serial data into the shift register under test, registered
busy  output  1  high while a run is in progress
done  output  1  high from end of run until next accepted start or reset
pass  output  1  valid when done; 1 iff err_cnt == 0
err_cnt  output  ERR_W  mismatch count, saturating

Behaviour:
- Reset: applied on the clk edge where rst_n == 0. State goes to IDLE and both LFSRs load SEED = 7'h7F. Outputs: sr_in_o=0, busy=0, done=0, pass=0, err_cnt=0.
- Reset mid-run aborts immediately with the same values. No partial verdict is reported.
- PRBS7: out bit = lfsr[6]; next = {lfsr[5:0], lfsr[6]^lfsr[5]}. With SEED 7'h7F the first 7 bits are 1; period 127 (64 ones, 63 zeros).
- State IDLE: start=1 -> RUN on the next cycle. On that transition: phase=0, period=0, tx_lfsr=SEED, rx_lfsr=SEED, err_cnt=0, done=0, pass=0.
- State RUN: busy=1. phase counts 0..BIT_CYCLES-1 and wraps; period increments on the wrap.
  - At phase 0 of every period: sr_in_o <= tx_lfsr[6], then tx_lfsr advances. Transmission continues through all NUM_BITS+DEPTH periods.
  - At phase SAMPLE_PHASE, when period >= DEPTH: compare sr_out_i to rx_lfsr[6], then rx_lfsr advances.
  - Mismatch -> err_cnt+1, saturating at 2^ERR_W-1.
- Run end: the last cycle of RUN is phase BIT_CYCLES-1 of period NUM_BITS+DEPTH-1. On the next cycle: DONE, busy=0, sr_in_o=0, done=1, pass=(err_cnt==0).
  - RUN length is exactly (NUM_BITS+DEPTH)*BIT_CYCLES cycles (1280 with defaults).
- State DONE: all results held. start=1 -> RUN, with the same initialisation as from IDLE.
- start while in RUN: ignored.
- start on the same edge as rst_n=0: reset wins.
- Counter widths: phase is clog2(BIT_CYCLES) bits; period is wide enough to hold NUM_BITS+DEPTH-1.
- Arithmetic is unsigned. No wrap of err_cnt past its maximum.

Optional Feature:
Macro SRCHK_FIRST_ERR_EN.
- Defined:
  - Adds output first_err_idx [15:0], set to 16'hFFFF on reset and on run start.
  - On the first mismatch of a run it latches (period - DEPTH), the index of the failing checked bit. Later mismatches do not change it.
  - Held through DONE.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Ideal loopback (model delays sr_in_o by DEPTH periods, sampled consistently), start pulse -> busy for 1280 cycles, then done=1, pass=1, err_cnt=0; first_err_idx=16'hFFFF if enabled.
- sr_out_i stuck at 0, start -> done after 1280 cycles, err_cnt=130, pass=0, first_err_idx=0.
- sr_out_i stuck at 1, start -> err_cnt=126, pass=0, first_err_idx=7.
- NUM_BITS=1024 with sr_out_i stuck at 0 -> err_cnt saturates at 255, pass=0.
- rst_n=0 for one cycle at cycle 500 of a run, with start asserted in the same cycle -> next cycle IDLE, busy=0, done=0, err_cnt=0, sr_in_o=0; a fresh start then yields the full clean result.
- start re-pulsed at cycle 100 of a run -> ignored, run still ends at cycle 1280; start pulsed in DONE -> results clear and a new run begins.

Source files
------------

// File: rtl/sr_prbs_checker.sv
// PRBS7 loopback checker for the latch-chain shift register: transmits PRBS7 into the chain and
// compares the returned stream against a DEPTH-period delayed copy. Optional macro: SRCHK_FIRST_ERR_EN.
module sr_prbs_checker #(
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned BIT_CYCLES   = 4,
    parameter int unsigned SAMPLE_PHASE = 3,
    parameter int unsigned NUM_BITS     = 256,
    parameter int unsigned ERR_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sr_out_i,
    output logic             sr_in_o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt
`ifdef SRCHK_FIRST_ERR_EN
    ,
    output logic [15:0]      first_err_idx
`endif
);

    localparam int unsigned PH_W  = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned PER_W = ((NUM_BITS + DEPTH) > 1) ? $clog2(NUM_BITS + DEPTH) : 1;

    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(BIT_CYCLES - 1);
    localparam logic [PH_W-1:0]  PH_SAMPLE = PH_W'(SAMPLE_PHASE);
    localparam logic [PER_W-1:0] PER_LAST  = PER_W'(NUM_BITS + DEPTH - 1);
    localparam logic [PER_W-1:0] PER_DEPTH = PER_W'(DEPTH);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;
    localparam logic [6:0]       SEED      = 7'h7F;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    function automatic logic [6:0] prbs_next(input logic [6:0] l);
        return {l[5:0], l[6] ^ l[5]};
    endfunction

    state_e             r_state,  w_state_nxt;
    logic [PH_W-1:0]    r_phase,  w_phase_nxt;
    logic [PER_W-1:0]   r_period, w_period_nxt;
    logic [6:0]         r_tx_lfsr, w_tx_lfsr_nxt;
    logic [6:0]         r_rx_lfsr, w_rx_lfsr_nxt;
    logic [ERR_W-1:0]   r_err_cnt, w_err_cnt_nxt;
    logic               r_sr_in,  w_sr_in_nxt;
    logic [15:0]        r_first_err, w_first_err_nxt;
    logic               w_sample;
    logic               w_mismatch;

    assign w_sample   = (r_state == StRun) && (r_phase == PH_SAMPLE) && (r_period >= PER_DEPTH);
    assign w_mismatch = w_sample && (sr_out_i != r_rx_lfsr[6]);

    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_period_nxt    = r_period;
        w_tx_lfsr_nxt   = r_tx_lfsr;
        w_rx_lfsr_nxt   = r_rx_lfsr;
        w_err_cnt_nxt   = r_err_cnt;
        w_sr_in_nxt     = r_sr_in;
        w_first_err_nxt = r_first_err;
        unique case (r_state)
            StIdle, StDone: begin
                if (start) begin
                    w_state_nxt     = StRun;
                    w_phase_nxt     = '0;
                    w_period_nxt    = '0;
                    w_tx_lfsr_nxt   = SEED;
                    w_rx_lfsr_nxt   = SEED;
                    w_err_cnt_nxt   = '0;
                    w_first_err_nxt = 16'hFFFF;
                end
            end
            StRun: begin
                if (r_phase == '0) begin
                    w_sr_in_nxt   = r_tx_lfsr[6];
                    w_tx_lfsr_nxt = prbs_next(r_tx_lfsr);
                end
                if (w_sample) begin
                    w_rx_lfsr_nxt = prbs_next(r_rx_lfsr);
                end
                if (w_mismatch) begin
                    // Zero count means this is the run's first mismatch.
                    if (r_err_cnt == '0) begin
                        w_first_err_nxt = 16'(r_period - PER_DEPTH);
                    end
                    if (r_err_cnt != ERR_MAX) begin
                        w_err_cnt_nxt = r_err_cnt + 1'b1;
                    end
                end
                if (r_phase == PH_LAST) begin
                    w_phase_nxt = '0;
                    if (r_period == PER_LAST) begin
                        w_state_nxt = StDone;
                        w_sr_in_nxt = 1'b0;
                    end else begin
                        w_period_nxt = r_period + 1'b1;
                    end
                end else begin
                    w_phase_nxt = r_phase + 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_phase     <= '0;
            r_period    <= '0;
            r_tx_lfsr   <= SEED;
            r_rx_lfsr   <= SEED;
            r_err_cnt   <= '0;
            r_sr_in     <= 1'b0;
            r_first_err <= 16'hFFFF;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_period    <= w_period_nxt;
            r_tx_lfsr   <= w_tx_lfsr_nxt;
            r_rx_lfsr   <= w_rx_lfsr_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
            r_sr_in     <= w_sr_in_nxt;
            r_first_err <= w_first_err_nxt;
        end
    end

    assign sr_in_o = r_sr_in;
    assign busy    = (r_state == StRun);
    assign done    = (r_state == StDone);
    assign pass    = done && (r_err_cnt == '0);
    assign err_cnt = r_err_cnt;

`ifdef SRCHK_FIRST_ERR_EN
    assign first_err_idx = r_first_err;
`else
    logic w_first_err_unused;
    assign w_first_err_unused = ^r_first_err;
`endif

endmodule

// File: tb/tb_sr_prbs_checker.sv
// Directed bench for sr_prbs_checker: table of loopback/stuck-at runs, plus hand sequences for
// mid-run reset, restart from DONE, ignored start, and error-counter saturation.
module tb_sr_prbs_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic        start_big;
    logic        sr_out_i;
    logic        sr_in_o, busy, done, pass;
    logic [7:0]  err_cnt;
    logic        sr_in_big, busy_big, done_big, pass_big;
    logic [7:0]  err_big;
`ifdef SRCHK_FIRST_ERR_EN
    logic [15:0] first_err_idx;
    logic [15:0] first_err_big;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int mode   = 0;  // 0 loopback, 1 stuck at 0, 2 stuck at 1

    // Ideal chain: sr_in_o delayed by DEPTH*BIT_CYCLES clocks.
    logic [255:0] r_dly = '0;
    always @(posedge clk) r_dly <= {r_dly[254:0], sr_in_o};
    assign sr_out_i = (mode == 0) ? r_dly[255] : (mode == 2);

    sr_prbs_checker u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sr_out_i (sr_out_i),
        .sr_in_o  (sr_in_o),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt)
`ifdef SRCHK_FIRST_ERR_EN
        ,
        .first_err_idx (first_err_idx)
`endif
    );

    sr_prbs_checker #(
        .NUM_BITS (1024)
    ) u_dut_big (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_big),
        .sr_out_i (1'b0),
        .sr_in_o  (sr_in_big),
        .busy     (busy_big),
        .done     (done_big),
        .pass     (pass_big),
        .err_cnt  (err_big)
`ifdef SRCHK_FIRST_ERR_EN
        ,
        .first_err_idx (first_err_big)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One full run; restart_at >= 0 re-pulses start at that RUN cycle (must be ignored).
    task automatic run_check(input string tag, input int exp_err, input logic exp_pass,
                             input logic [15:0] exp_first, input int restart_at);
        logic [15:0] prbs_ref;
        int c;
        prbs_ref = 16'hFE04;  // first 16 PRBS7 bits from seed 7F, bit 0 at MSB
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({tag, "_busy0"}, busy, 1);
        check({tag, "_done0"}, done, 0);
        check({tag, "_err0"}, err_cnt, 0);
        check({tag, "_pass0"}, pass, 0);
        c = 0;
        while (busy === 1'b1 && c < 6000) begin
            if ((c % 4) == 1 && (c / 4) < 16) begin
                check({tag, "_txbit"}, sr_in_o, prbs_ref[15 - c / 4]);
            end
            start = (c == restart_at);
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        check({tag, "_len"}, c, 1280);
        check({tag, "_done"}, done, 1);
        check({tag, "_err"}, err_cnt, exp_err);
        check({tag, "_pass"}, pass, exp_pass);
        check({tag, "_srin"}, sr_in_o, 0);
`ifdef SRCHK_FIRST_ERR_EN
        check({tag, "_first"}, first_err_idx, exp_first);
`else
        if (exp_first == 16'h0) begin end
`endif
        @(negedge clk);
        check({tag, "_hold"}, {done, err_cnt}, {1'b1, 8'(exp_err)});
    endtask

    typedef struct {
        int          md;
        int          exp_err;
        logic        exp_pass;
        logic [15:0] exp_first;
        string       name;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int c;
        vecs[0] = '{0, 0,   1'b1, 16'hFFFF, "loop"};
        vecs[1] = '{1, 130, 1'b0, 16'h0000, "stuck0"};
        vecs[2] = '{2, 126, 1'b0, 16'h0007, "stuck1"};

        rst_n     = 1'b0;
        start     = 1'b0;
        start_big = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_cnt, 0);
        check("rst_srin", sr_in_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        foreach (vecs[i]) begin
            mode = vecs[i].md;
            run_check(vecs[i].name, vecs[i].exp_err, vecs[i].exp_pass, vecs[i].exp_first, -1);
        end

        // Restart from DONE clears results; a start pulse at cycle 100 is ignored.
        mode = 1;
        run_check("restart", 130, 1'b0, 16'h0000, 100);

        // Reset at cycle 500 with start in the same cycle: reset wins.
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (500) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_err", err_cnt, 0);
        check("midrst_srin", sr_in_o, 0);
        check("midrst_pass", pass, 0);
        @(negedge clk);
        check("midrst_idle", {busy, done}, 2'b00);
        run_check("fresh", 0, 1'b1, 16'hFFFF, -1);

        // Long run with stuck-at-0 saturates the 8-bit counter.
        @(negedge clk) start_big = 1'b1;
        @(negedge clk) start_big = 1'b0;
        check("big_busy0", busy_big, 1);
        c = 0;
        while (busy_big === 1'b1 && c < 6000) begin
            @(negedge clk);
            c++;
        end
        check("big_len", c, 4352);
        check("big_done", done_big, 1);
        check("big_err", err_big, 255);
        check("big_pass", pass_big, 0);
`ifdef SRCHK_FIRST_ERR_EN
        check("big_first", first_err_big, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
